fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory read at a time, a 2-entry
// in-order instruction queue toward decode, and redirect handling that flushes in-flight work.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req_valid,
    output logic [31:0] im_req_addr,
    input  logic        im_req_ready,
    input  logic        im_rsp_valid,
    input  logic [31:0] im_rsp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] req_pc_reg;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, wr_ptr_reg;
    logic [31:0] q_pc_reg    [2];
    logic [31:0] q_instr_reg [2];
    logic        accept, push, pop;

    // A request is only offered when its response is guaranteed a free queue slot.
    assign im_req_valid = !reset && (state_reg == IDLE) && (count_reg != 2'd2) && !redirect_valid;
    assign im_req_addr  = fetch_pc_reg;
    assign accept       = im_req_valid && im_req_ready;
    assign push         = (state_reg == WAIT) && im_rsp_valid && !redirect_valid;

    assign out_valid = (count_reg != 2'd0);
    assign out_pc    = q_pc_reg[rd_ptr_reg];
    assign out_instr = q_instr_reg[rd_ptr_reg];
    assign out_pc4   = out_pc + 32'd4;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            // A response landing in the redirect cycle retires the outstanding read.
            if ((state_reg != IDLE) && !im_rsp_valid) begin
                state_next = DROP;
            end else begin
                state_next = IDLE;
            end
        end else begin
            case (state_reg)
                IDLE:    if (accept)       state_next = WAIT;
                WAIT:    if (im_rsp_valid) state_next = IDLE;
                DROP:    if (im_rsp_valid) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
        end else if (accept) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (redirect_valid) begin
            count_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            if (accept) begin
                req_pc_reg <= fetch_pc_reg;
            end
            if (redirect_valid) begin
                rd_ptr_reg <= 1'b0;
                wr_ptr_reg <= 1'b0;
            end else begin
                if (push) wr_ptr_reg <= !wr_ptr_reg;
                if (pop)  rd_ptr_reg <= !rd_ptr_reg;
            end
        end
    end

    // Queue payload needs no reset: count gates visibility of every entry.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    q_pc_reg[gi]    <= req_pc_reg;
                    q_instr_reg[gi] <= im_rsp_data;
                end
            end
        end
    endgenerate

endmodule
